triangle_arbiter: RTL and testbench

Round-robin arbiter that shares the single screen-normalization stage among `NUM_SRC` upstream triangle producers, such as parallel vertex-transform lanes. It selects one valid source per cycle and registers the chosen triangle into a one-deep output slot with a valid/ready handshake. The output slot drives the normalizer input. A flush sequencer drains the arbiter and the downstream stage at frame end so the rasterizer can swap buffers safely.

---
 rtl/triangle_arbiter.sv | 154 +++++++++++++++
 tb/tb_triangle_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_arbiter.sv
// Round-robin triangle arbiter with burst limit, one-deep output slot and a frame-end flush sequencer.
// Optional per-source grant counters are enabled by defining TRIANGLE_ARBITER_STATS_EN.
module triangle_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned BURST_LEN = 1,
    parameter int unsigned TRI_W     = 96
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0][TRI_W-1:0] in_triangle,
    input  logic [NUM_SRC-1:0]            in_valid,
    output logic [NUM_SRC-1:0]            in_ready,
    output logic [TRI_W-1:0]              out_triangle,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_SRC)-1:0]    out_src,
    input  logic                          downstream_busy,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          busy
`ifdef TRIANGLE_ARBITER_STATS_EN
    ,
    output logic [NUM_SRC-1:0][31:0]      grant_count
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = 4;

    typedef logic [TRI_W-1:0] triangle_t;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, run_cnt;
    logic             out_valid_q;
    triangle_t        out_tri_q;
    logic [SRC_W-1:0] out_src_q;

    logic             slot_free, grant_en, gnt_found, grant;
    logic [SRC_W-1:0] gnt_idx, scan_sel, gnt_next;
    int unsigned      scan_idx;

    assign slot_free = !out_valid_q || out_ready;
    assign grant_en  = !rst && (state_q == RUN) && slot_free && !flush_req;
    assign grant     = grant_en && gnt_found;

    // First valid source at or after ptr, wrapping modulo NUM_SRC.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        scan_sel  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = (32'(ptr_q) + k) % NUM_SRC;
            scan_sel = SRC_W'(scan_idx);
            if (!gnt_found && in_valid[scan_sel]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_sel;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // A grant that skips the pointer source starts a fresh burst.
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_next = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
        run_cnt  = (gnt_idx == ptr_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        if (grant) begin
            if (32'(run_cnt) < BURST_LEN) begin
                ptr_d = gnt_idx;
                cnt_d = run_cnt;
            end else begin
                ptr_d = gnt_next;
                cnt_d = '0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        busy       = out_valid_q || (state_q != RUN);
        case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q && !downstream_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_tri_q   <= '0;
            out_src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                out_valid_q <= 1'b1;
                out_tri_q   <= in_triangle[gnt_idx];
                out_src_q   <= gnt_idx;
            end else if (slot_free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_triangle = out_tri_q;
    assign out_src      = out_src_q;

`ifdef TRIANGLE_ARBITER_STATS_EN
    logic [NUM_SRC-1:0][31:0] gcnt_q;

    // Per-frame saturating counters, cleared as the flush completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
        end else if (state_q == DONE) begin
            gcnt_q <= '0;
        end else if (grant && (gcnt_q[gnt_idx] != '1)) begin
            gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 32'd1;
        end
    end

    assign grant_count = gcnt_q;
`endif

endmodule

// File: tb/tb_triangle_arbiter.sv
// Randomized and directed bench for triangle_arbiter: two instances (BURST_LEN 1 and 3) checked
// every cycle against a behavioural model of the arbitration, slot and flush rules.
module tb_triangle_arbiter;

    localparam int N  = 4;
    localparam int TW = 96;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0][TW-1:0] itri [2];
    logic [N-1:0]         iv   [2];
    logic [N-1:0]         rdy  [2];
    logic [TW-1:0]        otri [2];
    logic                 ov   [2];
    logic                 ordy [2];
    logic [1:0]           osrc [2];
    logic                 dbusy[2];
    logic                 freq [2];
    logic                 fd   [2];
    logic                 bsy  [2];
`ifdef TRIANGLE_ARBITER_STATS_EN
    logic [N-1:0][31:0]   gc   [2];
`endif

    triangle_arbiter #(.NUM_SRC(N), .BURST_LEN(1), .TRI_W(TW)) u_dut0 (
        .clk(clk), .rst(rst), .in_triangle(itri[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .out_triangle(otri[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_src(osrc[0]),
        .downstream_busy(dbusy[0]), .flush_req(freq[0]), .flush_done(fd[0]), .busy(bsy[0])
`ifdef TRIANGLE_ARBITER_STATS_EN
        , .grant_count(gc[0])
`endif
    );

    triangle_arbiter #(.NUM_SRC(N), .BURST_LEN(3), .TRI_W(TW)) u_dut1 (
        .clk(clk), .rst(rst), .in_triangle(itri[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .out_triangle(otri[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_src(osrc[1]),
        .downstream_busy(dbusy[1]), .flush_req(freq[1]), .flush_done(fd[1]), .busy(bsy[1])
`ifdef TRIANGLE_ARBITER_STATS_EN
        , .grant_count(gc[1])
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase 0 = accepting, 1 = draining, 2 = drain-complete cycle.
    int           blen [2] = '{1, 3};
    logic         m_ov [2];
    logic [TW-1:0] m_tri[2];
    int           m_src[2], m_ptr[2], m_cnt[2], m_phase[2];
    int           m_gc [2][N];
    int           exp_g[2];
    logic [N-1:0] exp_rdy[2];
    logic [N-1:0] acc[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 1'b0; m_tri[i] = '0; m_src[i] = 0;
            m_ptr[i] = 0; m_cnt[i] = 0; m_phase[i] = 0;
            for (int s = 0; s < N; s++) m_gc[i][s] = 0;
        end
    endtask

    function automatic int model_grant(int i);
        if (rst || m_phase[i] != 0 || freq[i] || (m_ov[i] && !ordy[i])) return -1;
        for (int k = 0; k < N; k++) begin
            if (iv[i][(m_ptr[i] + k) % N]) return (m_ptr[i] + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(int i);
        int g, run, nphase;
        g = exp_g[i];
        if (rst) begin
            m_ov[i] = 1'b0; m_tri[i] = '0; m_src[i] = 0;
            m_ptr[i] = 0; m_cnt[i] = 0; m_phase[i] = 0;
            for (int s = 0; s < N; s++) m_gc[i][s] = 0;
            return;
        end
        nphase = m_phase[i];
        if (m_phase[i] == 0 && freq[i]) nphase = 1;
        else if (m_phase[i] == 1 && !m_ov[i] && !dbusy[i]) nphase = 2;
        else if (m_phase[i] == 2) nphase = 0;
        if (m_phase[i] == 2) begin
            for (int s = 0; s < N; s++) m_gc[i][s] = 0;
        end else if (g >= 0) begin
            m_gc[i][g]++;
        end
        if (g >= 0) begin
            m_ov[i]  = 1'b1;
            m_tri[i] = itri[i][g];
            m_src[i] = g;
            run = (g == m_ptr[i]) ? m_cnt[i] + 1 : 1;
            if (run < blen[i]) begin
                m_ptr[i] = g; m_cnt[i] = run;
            end else begin
                m_ptr[i] = (g + 1) % N; m_cnt[i] = 0;
            end
        end else if (!m_ov[i] || ordy[i]) begin
            m_ov[i] = 1'b0;
        end
        m_phase[i] = nphase;
    endtask

    // Settle inputs, record expected/observed acceptance, then clock both DUTs and the model.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_g[i]   = model_grant(i);
            exp_rdy[i] = '0;
            if (exp_g[i] >= 0) exp_rdy[i][exp_g[i]] = 1'b1;
            acc[i] = rdy[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_update(i);
    endtask

    // Sources in mask keep offering; a source gets a fresh triangle only once accepted.
    task automatic refresh(int i, logic [N-1:0] mask);
        for (int s = 0; s < N; s++) begin
            if (mask[s]) begin
                if (!iv[i][s] || acc[i][s]) begin
                    iv[i][s]   = 1'b1;
                    itri[i][s] = {$urandom, $urandom, $urandom};
                end
            end else begin
                iv[i][s] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            itri[i] = '0; iv[i] = '0; ordy[i] = 1'b1; dbusy[i] = 1'b0; freq[i] = 1'b0;
            acc[i] = '0;
        end
        rst = 1'b1;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ov[i], otri[i], osrc[i], rdy[i], fd[i], bsy[i]} !== '0) begin
                errors++;
                $display("FAIL reset_values inst=%0d ov=%b src=%0d rdy=%b fd=%b busy=%b tri=%h expected all 0",
                         i, ov[i], osrc[i], rdy[i], fd[i], bsy[i], otri[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fairness();
        refresh(0, 4'hF);
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (acc[0] !== exp_rdy[0]) begin
                errors++;
                $display("FAIL fair_in_ready k=%0d got=%b exp=%b", k, acc[0], exp_rdy[0]);
            end
            checks++;
            if (ov[0] !== 1'b1 || osrc[0] !== 2'(k % 4) || otri[0] !== m_tri[0]) begin
                errors++;
                $display("FAIL fair_order k=%0d got ov=%b src=%0d exp ov=1 src=%0d", k, ov[0], osrc[0], k % 4);
            end
            refresh(0, 4'hF);
        end
        iv[0] = '0;
    endtask

    task automatic test_burst();
        int e;
        refresh(1, 4'b0110);
        for (int k = 0; k < 13; k++) begin
            step();
            e = ((k / 3) % 2 == 0) ? 1 : 2;
            checks++;
            if (acc[1] !== exp_rdy[1] || ov[1] !== 1'b1 || osrc[1] !== 2'(e) || otri[1] !== m_tri[1]) begin
                errors++;
                $display("FAIL burst_order k=%0d got src=%0d rdy=%b exp src=%0d rdy=%b",
                         k, osrc[1], acc[1], e, exp_rdy[1]);
            end
            refresh(1, 4'b0110);
        end
        iv[1] = '0;
        step();
    endtask

    task automatic test_stall();
        logic [TW-1:0] held, pend;
        ordy[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            refresh(0, 4'b1000);
            step();
        end
        held = m_tri[0];
        ordy[0] = 1'b0;
        refresh(0, 4'b1000);
        pend = itri[0][3];
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (acc[0] !== 4'b0000 || ov[0] !== 1'b1 || otri[0] !== held || osrc[0] !== 2'd3) begin
                errors++;
                $display("FAIL stall_hold k=%0d rdy=%b ov=%b src=%0d tri=%h exp rdy=0000 ov=1 src=3 tri=%h",
                         k, acc[0], ov[0], osrc[0], otri[0], held);
            end
            refresh(0, 4'b1000);
        end
        ordy[0] = 1'b1;
        step();
        checks++;
        if (acc[0] !== 4'b1000 || otri[0] !== pend || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release rdy=%b tri=%h exp rdy=1000 tri=%h", acc[0], otri[0], pend);
        end
        iv[0] = '0;
    endtask

    task automatic test_flush_backlog();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 9; c++) begin
            refresh(0, 4'b0011);
            ordy[0]  = (c == 0 || c >= 4);
            dbusy[0] = (c >= 1 && c <= 4);
            freq[0]  = (c == 1);
            step();
            if (fd[0] === 1'b1) pulses++;
            checks++;
            if (fd[0] !== (c == 5) || bsy[0] !== (m_ov[0] || m_phase[0] != 0) || ov[0] !== m_ov[0]) begin
                errors++;
                $display("FAIL flush_backlog c=%0d fd=%b busy=%b ov=%b exp fd=%b", c, fd[0], bsy[0], ov[0], c == 5);
            end
            if (c >= 1 && c <= 6) begin
                checks++;
                if (acc[0] !== 4'b0000) begin
                    errors++;
                    $display("FAIL flush_no_grant c=%0d rdy=%b exp=0000", c, acc[0]);
                end
            end
        end
        freq[0] = 1'b0; dbusy[0] = 1'b0; ordy[0] = 1'b1;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL flush_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_flush_idle();
        iv[0] = '0; ordy[0] = 1'b1;
        step();
        step();
        for (int c = 0; c < 4; c++) begin
            freq[0] = (c == 0);
            step();
            checks++;
            if (fd[0] !== (c == 1) || fd[0] !== (m_phase[0] == 2)) begin
                errors++;
                $display("FAIL flush_idle c=%0d fd=%b exp=%b", c, fd[0], c == 1);
            end
        end
        freq[0] = 1'b0;
    endtask

    task automatic test_reset_midstream();
        ordy[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            refresh(0, 4'hF);
            step();
        end
        refresh(0, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ov[0], otri[0], osrc[0], rdy[0], fd[0], bsy[0]} !== '0) begin
            errors++;
            $display("FAIL async_reset ov=%b src=%0d rdy=%b fd=%b busy=%b tri=%h expected all 0",
                     ov[0], osrc[0], rdy[0], fd[0], bsy[0], otri[0]);
        end
        step();
        @(negedge clk);
        rst = 1'b0;
        acc[0] = '0;
        step();
        checks++;
        if (acc[0] !== 4'b0001 || ov[0] !== 1'b1 || osrc[0] !== 2'd0 || otri[0] !== itri[0][0]) begin
            errors++;
            $display("FAIL reset_first_grant rdy=%b ov=%b src=%0d exp rdy=0001 ov=1 src=0", acc[0], ov[0], osrc[0]);
        end
        iv[0] = '0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 2; i++) begin
                for (int s = 0; s < N; s++) begin
                    if (!(iv[i][s] && !acc[i][s])) begin
                        iv[i][s]   = 1'($urandom_range(0, 1));
                        itri[i][s] = {$urandom, $urandom, $urandom};
                    end
                end
                ordy[i]  = ($urandom_range(0, 3) != 0);
                dbusy[i] = ($urandom_range(0, 2) == 0);
                freq[i]  = ($urandom_range(0, 15) == 0);
            end
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (acc[i] !== exp_rdy[i]) begin
                    errors++;
                    $display("FAIL rand_in_ready k=%0d inst=%0d got=%b exp=%b", k, i, acc[i], exp_rdy[i]);
                end
                checks++;
                if (ov[i] !== m_ov[i] || osrc[i] !== 2'(m_src[i]) || otri[i] !== m_tri[i] ||
                    fd[i] !== (m_phase[i] == 2) || bsy[i] !== (m_ov[i] || m_phase[i] != 0)) begin
                    errors++;
                    $display("FAIL rand_outputs k=%0d inst=%0d got ov=%b src=%0d fd=%b busy=%b exp ov=%b src=%0d fd=%b",
                             k, i, ov[i], osrc[i], fd[i], bsy[i], m_ov[i], m_src[i], m_phase[i] == 2);
                end
`ifdef TRIANGLE_ARBITER_STATS_EN
                for (int s = 0; s < N; s++) begin
                    checks++;
                    if (gc[i][s] !== 32'(m_gc[i][s])) begin
                        errors++;
                        $display("FAIL rand_count k=%0d inst=%0d src=%0d got=%0d exp=%0d", k, i, s, gc[i][s], m_gc[i][s]);
                    end
                end
`endif
            end
        end
        for (int i = 0; i < 2; i++) begin
            iv[i] = '0; ordy[i] = 1'b1; dbusy[i] = 1'b0; freq[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) step();
    endtask

`ifdef TRIANGLE_ARBITER_STATS_EN
    task automatic test_stats();
        freq[0] = 1'b1;
        step();
        freq[0] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 10; k++) begin
            refresh(0, 4'b0100);
            step();
        end
        iv[0] = '0;
        step();
        for (int s = 0; s < N; s++) begin
            checks++;
            if (gc[0][s] !== ((s == 2) ? 32'd10 : 32'd0) || gc[0][s] !== 32'(m_gc[0][s])) begin
                errors++;
                $display("FAIL stats_count src=%0d got=%0d exp=%0d", s, gc[0][s], (s == 2) ? 10 : 0);
            end
        end
        freq[0] = 1'b1;
        step();
        freq[0] = 1'b0;
        for (int k = 0; k < 2; k++) step();
        checks++;
        if (gc[0] !== '0) begin
            errors++;
            $display("FAIL stats_clear got=%h exp=0", gc[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_burst();
        test_stall();
        test_flush_backlog();
        test_flush_idle();
        test_reset_midstream();
        test_random();
`ifdef TRIANGLE_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
